// File: rtl/hy207_pkg.sv
// hy207_pkg: shared types and constants for the HY-207 board blocks
package hy207_pkg;
  typedef enum logic [1:0] {
    LATCH = 2'd0,
    BLINK = 2'd1,
    CHASE = 2'd2
  } mode_t;
  localparam logic LED_ON  = 1'b0;
  localparam logic LED_OFF = 1'b1;
  localparam int NUM_BTN = 4;
  localparam int NUM_LED = 8;
  function automatic mode_t next_mode(input mode_t m);
    return (m == LATCH) ? BLINK : (m == BLINK) ? CHASE : LATCH;
  endfunction
endpackage

// File: rtl/led_bank_ctrl_tick_gen.sv
// tick_gen: free-running prescaler emitting a one-cycle tick at each wrap
module tick_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign o_tick = (cnt == W'(DIV - 1));
  // count 0..DIV-1 and wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= o_tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/led_bank_ctrl.sv
// led_bank_ctrl: button-latched LED bank with LATCH/BLINK/CHASE sequencer and buzzer
module led_bank_ctrl
  import hy207_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 4,
  parameter int HOLD_TICKS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] i_flag_btn_down,
  input  logic [NUM_BTN-1:0] i_flag_btn_up,
  output logic [NUM_LED-1:0] o_led_n,
  output logic               o_buzzer_n,
  output logic [1:0]         o_mode
);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  logic               tick;
  logic [NUM_BTN-1:0] latch, latch_nx;
  mode_t              mode, mode_nx;
  logic               phase, phase_nx;
  logic [2:0]         pos, pos_nx;
  logic               dir, dir_nx;
  logic [HW-1:0]      hold_cnt, hold_cnt_nx;
  logic               hold_act, hold_act_nx;
  logic [1:0]         beep_cnt, beep_nx;
  logic               long_p, short_p;
  logic [NUM_LED-1:0] led_nx;
  logic               unused_up;
  assign unused_up = ^i_flag_btn_up[2:0];
  tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .o_tick(tick)
  );
  assign long_p  = i_flag_btn_up[3] && hold_act && (hold_cnt >= HW'(HOLD_TICKS));
  assign short_p = i_flag_btn_up[3] && hold_act && !long_p;
  // next state: hold timing, toggles, chase walk, mode advance and beep
  always_comb begin
    latch_nx    = latch;
    mode_nx     = mode;
    phase_nx    = phase ^ tick;
    pos_nx      = pos;
    dir_nx      = dir;
    hold_act_nx = hold_act;
    hold_cnt_nx = (hold_act && tick && hold_cnt < HW'(HOLD_TICKS)) ? hold_cnt + 1'b1 : hold_cnt;
    beep_nx     = (tick && beep_cnt != 2'd0) ? beep_cnt - 2'd1 : beep_cnt;
    if (i_flag_btn_up[3]) hold_act_nx = 1'b0;
    if (i_flag_btn_down[3]) begin
      hold_act_nx = 1'b1;
      hold_cnt_nx = '0;
    end
    if (mode != CHASE) latch_nx = latch ^ {short_p, i_flag_btn_down[2:0]};
    else begin
      dir_nx = dir ^ i_flag_btn_down[0];
      pos_nx = tick ? (dir ? pos - 3'd1 : pos + 3'd1) : pos;
    end
    if (long_p) begin
      mode_nx = next_mode(mode);
      beep_nx = 2'd1;
      if (mode_nx == CHASE) begin
        pos_nx = 3'd0;
        dir_nx = 1'b0;
      end
    end
  end
  // LED pattern from the registered state; upper LEDs mirror the lower ones inverted
  always_comb begin
    led_nx = (mode == CHASE) ? ~(NUM_LED'(1) << pos)
           : (mode == BLINK && !phase) ? {NUM_LED{LED_OFF}}
           : {latch, ~latch};
  end
  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      latch      <= '0;
      mode       <= LATCH;
      phase      <= 1'b0;
      pos        <= 3'd0;
      dir        <= 1'b0;
      hold_cnt   <= '0;
      hold_act   <= 1'b0;
      beep_cnt   <= 2'd0;
      o_led_n    <= 8'h0F;
      o_buzzer_n <= LED_OFF;
      o_mode     <= 2'd0;
    end else begin
      latch      <= latch_nx;
      mode       <= mode_nx;
      phase      <= phase_nx;
      pos        <= pos_nx;
      dir        <= dir_nx;
      hold_cnt   <= hold_cnt_nx;
      hold_act   <= hold_act_nx;
      beep_cnt   <= beep_nx;
      o_led_n    <= led_nx;
      o_buzzer_n <= (beep_cnt == 2'd0);
      o_mode     <= mode;
    end
endmodule

// File: tb/tb_led_bank_ctrl.sv
// tb_led_bank_ctrl: directed scoreboard bench for led_bank_ctrl
module tb_led_bank_ctrl;
  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] val;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dn = 4'd0;
  logic [3:0] up = 4'd0;
  logic [7:0] o_led_n;
  logic       o_buzzer_n;
  logic [1:0] o_mode;
  int         compared = 0;
  int         mism = 0;
  int         cyc;
  exp_t       sb[$];

  led_bank_ctrl #(.CLK_HZ(8), .TICK_HZ(2), .HOLD_TICKS(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_flag_btn_down(dn),
    .i_flag_btn_up  (up),
    .o_led_n        (o_led_n),
    .o_buzzer_n     (o_buzzer_n),
    .o_mode         (o_mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_dn(input logic [3:0] m);
    dn = m;
    step();
    dn = 4'd0;
  endtask

  task automatic pulse_up(input logic [3:0] m);
    up = m;
    step();
    up = 4'd0;
  endtask

  task automatic short_press();
    pulse_dn(4'h8);
    step(3);
    pulse_up(4'h8);
  endtask

  task automatic long_press();
    pulse_dn(4'h8);
    step(12);
    pulse_up(4'h8);
  endtask

  task automatic expect_out(input string tag, input int sel, input logic [7:0] val);
    sb.push_back('{tag, sel, val});
  endtask

  task automatic check_all();
    exp_t e;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = (e.sel == 0) ? o_led_n : (e.sel == 1) ? {7'd0, o_buzzer_n} : {6'd0, o_mode};
      compared++;
      assert (obs === e.val) else begin
        mism++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic wait_change(input string tag, input logic [7:0] exp);
    logic [7:0] prev;
    int n;
    prev = o_led_n;
    n = 0;
    while (o_led_n === prev && n < 12) begin
      step();
      n++;
    end
    expect_out(tag, 0, exp);
    check_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n1e, nff;
    step(3);
    rst_n = 1'b1;
    step(2);
    expect_out("rst_led", 0, 8'h0F);
    expect_out("rst_buz", 1, 8'h01);
    expect_out("rst_mode", 2, 8'h00);
    check_all();

    pulse_dn(4'h2);
    expect_out("lat_n1", 0, 8'h0F);
    check_all();
    step();
    expect_out("btn1_on", 0, 8'h2D);
    check_all();
    pulse_dn(4'h2);
    step();
    expect_out("btn1_off", 0, 8'h0F);
    check_all();

    short_press();
    step();
    expect_out("short3_led", 0, 8'h87);
    expect_out("short3_mode", 2, 8'h00);
    check_all();
    short_press();
    pulse_dn(4'h1);
    step();
    expect_out("latch1_led", 0, 8'h1E);
    check_all();

    long_press();
    step();
    expect_out("blink_mode", 2, 8'h01);
    expect_out("blink_beep", 1, 8'h00);
    check_all();
    n1e = 0;
    nff = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      compared++;
      assert (o_led_n === 8'h1E || o_led_n === 8'hFF) else begin
        mism++;
        $error("FAIL blink_val observed=%h expected=1e|ff", o_led_n);
      end
      if (o_led_n === 8'h1E) n1e++;
      else nff++;
    end
    compared++;
    assert (n1e > 0 && nff > 0) else begin
      mism++;
      $error("FAIL blink_alt observed=%0d/%0d expected=both>0", n1e, nff);
    end
    expect_out("beep_end", 1, 8'h01);
    check_all();

    long_press();
    step();
    expect_out("chase_mode", 2, 8'h02);
    expect_out("chase_p0", 0, 8'hFE);
    check_all();
    wait_change("chase_p1", 8'hFD);
    wait_change("chase_p2", 8'hFB);
    pulse_dn(4'h1);
    wait_change("chase_r1", 8'hFD);
    wait_change("chase_r0", 8'hFE);
    wait_change("chase_r7", 8'h7F);
    pulse_dn(4'h2);
    short_press();
    expect_out("chase_hold", 2, 8'h02);
    check_all();
    long_press();
    step();
    expect_out("back_mode", 2, 8'h00);
    expect_out("back_latch", 0, 8'h1E);
    check_all();

    pulse_dn(4'h1);
    pulse_dn(4'h7);
    step();
    expect_out("multi_tog", 0, 8'h78);
    check_all();

    pulse_dn(4'h8);
    step(8);
    while ((cyc + 1) % 4 != 1) step();
    pulse_up(4'h8);
    pulse_dn(4'h8);
    expect_out("pre_rst_mode", 2, 8'h01);
    expect_out("pre_rst_beep", 1, 8'h00);
    check_all();
    #1 rst_n = 1'b0;
    #1;
    expect_out("async_led", 0, 8'h0F);
    expect_out("async_buz", 1, 8'h01);
    expect_out("async_mode", 2, 8'h00);
    check_all();
    step(2);
    rst_n = 1'b1;
    step(3);
    pulse_up(4'h8);
    step(2);
    expect_out("post_up_mode", 2, 8'h00);
    expect_out("post_up_led", 0, 8'h0F);
    expect_out("post_up_buz", 1, 8'h01);
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
